alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Execute-stage issue controller that sits on the operand/select side of the 32-bit ALU. It accepts a decoded instruction slot (opcode, funct, register values, immediate) over a valid/ready handshake and derives the ALU select code and operands. It drives the ALU for one cycle, captures the result, then presents it downstream with zero and branch-taken flags over a second valid/ready handshake.

## Interface
Parameters:
- none; widths fixed at 32-bit datapath, 6-bit opcode/funct, 16-bit immediate, 4-bit select.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  instruction slot valid.
- in_ready  out  1  controller can accept; high only in IDLE and only while reset is low.
- opcode  in  6  instruction opcode.
- funct  in  6  R-type function field.
- rs_val  in  32  first source register value.
- rt_val  in  32  second source register value.
- imm  in  16  immediate field.
- alu_op1  out  32  ALU operand 1 (registered).
- alu_op2  out  32  ALU operand 2 (registered).
- alu_sel  out  4  ALU select (registered).
- alu_c  in  32  ALU combinational result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  32  captured ALU result.
- zero  out  1  result == 0, computed locally from alu_c.
- branch_taken  out  1  BEQ: zero; BNE: !zero; all other instructions: 0.
- illegal  out  1  instruction not decodable.

## Operation
- Select codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- R-type (opcode 0x00), op1=rs_val, op2=rt_val:
  - funct 0x24 AND, 0x25 OR, 0x20 ADD, 0x22 SUB, 0x2A SLT, 0x27 NOR.
  - Any other funct is illegal.
- I-type, op1=rs_val:
  - 0x08 ADDI: ADD, op2 = sign-extended imm.
  - 0x0C ANDI: AND, op2 = zero-extended imm.
  - 0x0D ORI: OR, op2 = zero-extended imm.
  - 0x0A SLTI: SLT, op2 = sign-extended imm.
  - 0x23 LW, 0x2B SW: ADD, op2 = sign-extended imm (address).
  - 0x04 BEQ, 0x05 BNE: SUB, op2 = rt_val.
  - Any other opcode is illegal.
- FSM states IDLE, EXEC, DONE:
  - IDLE: in_ready=1. On in_valid, register decoded op1/op2/sel and a branch-kind tag. Legal → EXEC; illegal → DONE with illegal=1, result=0, zero=0, branch_taken=0, ALU outputs unchanged.
  - EXEC: ALU operands stable one full cycle. At the next edge capture result=alu_c, zero=(alu_c==0), branch_taken per tag, illegal=0 → DONE.
  - DONE: out_valid=1. result and flags hold until out_valid&&out_ready, then → IDLE. in_valid is ignored in DONE.
- Arithmetic is performed by the ALU; no width changes except the 16→32 extension. SLT signedness is whatever the ALU returns.

## Timing
- Reset (synchronous): state=IDLE, alu_op1=0, alu_op2=0, alu_sel=0000, result=0, zero=0, branch_taken=0, illegal=0, out_valid=0. in_ready is 0 during any cycle with reset high.
- Legal latency: accept at edge N; EXEC during cycle N..N+1; capture at edge N+1; out_valid high from N+1.
- Illegal latency: out_valid high from edge N (one edge after accept).
- Throughput: at most one instruction per 3 cycles (legal). No accept in the same cycle as the output handshake.
- Reset asserted in EXEC or DONE: in-flight instruction is dropped; no out_valid after reset.
- out_ready held high before out_valid has no effect.

## Structure
- Shared package alu_pkg holds:
  - opcode and funct constants;
  - the six select codes;
  - the FSM state enum (2-bit);
  - the branch-kind enum (NONE/BEQ/BNE).
- One combinational sub-module, alu_decode: opcode/funct/imm/rs_val/rt_val → op1, op2, sel, branch kind, illegal.
- The top holds the FSM and registers. The bench instantiates it together with the ALU.

## Test plan
- Reset while in DONE → next cycle out_valid=0, in_ready=1, all outputs at reset values.
- ADD: R-type funct 0x20, rs=5, rt=7 → alu_sel=0010, out_valid one edge after EXEC, result=12, zero=0, branch_taken=0.
- Branches with rs=rt=0x00001234:
  - BEQ → sel=0110, result=0, zero=1, branch_taken=1.
  - BNE, same operands → branch_taken=0.
- Immediate extension:
  - ADDI, rs=10, imm=0xFFFF → alu_op2=0xFFFFFFFF, result=9.
  - ORI, rs=0, imm=0x8000 → alu_op2=0x00008000, result=0x00008000.
- Backpressure: hold out_ready=0 for 4 cycles with in_valid=1 → result stable, in_ready=0, no new accept. Then raise out_ready → handshake, IDLE, next instruction accepted.
- Illegal: R-type funct 0x18 → out_valid one edge after accept, illegal=1, result=0, alu_sel unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and enums for the ALU issue controller
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOR = 4'b1100;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;

  typedef enum logic [1:0] {BR_NONE, BR_BEQ, BR_BNE} br_kind_e;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational decode of an instruction slot into ALU operands and select
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  input  logic [15:0] imm_i,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [3:0]  sel_o,
  output br_kind_e    br_kind_o,
  output logic        illegal_o
);

  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign imm_sext = {{16{imm_i[15]}}, imm_i};
  assign imm_zext = {16'h0000, imm_i};

  always_comb begin
    op1_o     = rs_val_i;
    op2_o     = rt_val_i;
    sel_o     = SEL_AND;
    br_kind_o = BR_NONE;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_AND:  sel_o = SEL_AND;
          FN_OR:   sel_o = SEL_OR;
          FN_ADD:  sel_o = SEL_ADD;
          FN_SUB:  sel_o = SEL_SUB;
          FN_SLT:  sel_o = SEL_SLT;
          FN_NOR:  sel_o = SEL_NOR;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        sel_o = SEL_ADD;
        op2_o = imm_sext;
      end
      OP_ANDI: begin
        sel_o = SEL_AND;
        op2_o = imm_zext;
      end
      OP_ORI: begin
        sel_o = SEL_OR;
        op2_o = imm_zext;
      end
      OP_SLTI: begin
        sel_o = SEL_SLT;
        op2_o = imm_sext;
      end
      OP_BEQ: begin
        sel_o     = SEL_SUB;
        br_kind_o = BR_BEQ;
      end
      OP_BNE: begin
        sel_o     = SEL_SUB;
        br_kind_o = BR_BNE;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - execute-stage issue FSM driving the ALU and returning result and flags
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        branch_taken,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d, result_q, result_d;
  logic [3:0]  sel_q, sel_d;
  br_kind_e    br_q, br_d;
  logic        zero_q, zero_d, bt_q, bt_d, illegal_q, illegal_d;

  logic [31:0] dec_op1, dec_op2;
  logic [3:0]  dec_sel;
  br_kind_e    dec_br;
  logic        dec_illegal;
  logic        alu_zero;

  alu_decode u_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .rs_val_i  (rs_val),
    .rt_val_i  (rt_val),
    .imm_i     (imm),
    .op1_o     (dec_op1),
    .op2_o     (dec_op2),
    .sel_o     (dec_sel),
    .br_kind_o (dec_br),
    .illegal_o (dec_illegal)
  );

  assign alu_zero = (alu_c == 32'd0);

  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sel_d     = sel_q;
    br_d      = br_q;
    result_d  = result_q;
    zero_d    = zero_q;
    bt_d      = bt_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Illegal slots skip the ALU entirely so its operands stay as they were.
          if (dec_illegal) begin
            illegal_d = 1'b1;
            result_d  = 32'd0;
            zero_d    = 1'b0;
            bt_d      = 1'b0;
            state_d   = ST_DONE;
          end else begin
            op1_d   = dec_op1;
            op2_d   = dec_op2;
            sel_d   = dec_sel;
            br_d    = dec_br;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        result_d  = alu_c;
        zero_d    = alu_zero;
        bt_d      = ((br_q == BR_BEQ) && alu_zero) || ((br_q == BR_BNE) && !alu_zero);
        illegal_d = 1'b0;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      sel_q     <= SEL_AND;
      br_q      <= BR_NONE;
      result_q  <= 32'd0;
      zero_q    <= 1'b0;
      bt_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      sel_q     <= sel_d;
      br_q      <= br_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      bt_q      <= bt_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE) && !reset;
  assign out_valid    = (state_q == ST_DONE);
  assign alu_op1      = op1_q;
  assign alu_op2      = op2_q;
  assign alu_sel      = sel_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign branch_taken = bt_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_val, rt_val, alu_op1, alu_op2, alu_c, result;
  logic [15:0] imm;
  logic [3:0]  alu_sel;
  logic        zero, branch_taken, illegal;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        bt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .funct        (funct),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .imm          (imm),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_sel      (alu_sel),
    .alu_c        (alu_c),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  always_comb begin
    alu_c = 32'd0;
    case (alu_sel)
      4'b0000: alu_c = alu_op1 & alu_op2;
      4'b0001: alu_c = alu_op1 | alu_op2;
      4'b0010: alu_c = alu_op1 + alu_op2;
      4'b0110: alu_c = alu_op1 - alu_op2;
      4'b0111: alu_c = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      4'b1100: alu_c = ~(alu_op1 | alu_op2);
      default: alu_c = 32'd0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] im);
    opcode = op; funct = fn; rs_val = rs; rt_val = rt; imm = im;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_tests++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_result"},  result, e.res);
      chk({tag, "_zero"},    {31'd0, zero}, {31'd0, e.z});
      chk({tag, "_bt"},      {31'd0, branch_taken}, {31'd0, e.bt});
      chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, e.ill});
    end
  endtask

  // Issue one instruction with out_ready high, check decode/latency and drain through the scoreboard.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                     input logic [3:0] esel, input logic [31:0] eop2,
                     input logic [31:0] eres, input logic ez, input logic ebt, input logic eill);
    int lat;
    exp_t e;
    e.res = eres; e.z = ez; e.bt = ebt; e.ill = eill;
    sb.push_back(e);
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    drive(op, fn, rs, rt, im);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_sel"}, {28'd0, alu_sel}, {28'd0, esel});
    chk({tag, "_op2"}, alu_op2, eop2);
    lat = 0;
    while (!out_valid && lat < 8) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, eill ? 32'd0 : 32'd1);
    pop_check(tag);
    step();
    chk({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(6'h00, 6'h00, 32'd0, 32'd0, 16'd0);
    step();
    step();
    chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sel", {28'd0, alu_sel}, 32'd0);
    chk("rst_op1", alu_op1, 32'd0);
    chk("rst_result", result, 32'd0);

    run("add",  6'h00, 6'h20, 32'd5, 32'd7, 16'd0, 4'b0010, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
    run("beq",  6'h04, 6'h00, 32'h1234, 32'h1234, 16'd0, 4'b0110, 32'h1234, 32'd0, 1'b1, 1'b1, 1'b0);
    run("bne",  6'h05, 6'h00, 32'h1234, 32'h1234, 16'd0, 4'b0110, 32'h1234, 32'd0, 1'b1, 1'b0, 1'b0);
    run("bne_t", 6'h05, 6'h00, 32'd3, 32'd1, 16'd0, 4'b0110, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
    run("addi", 6'h08, 6'h00, 32'd10, 32'd99, 16'hFFFF, 4'b0010, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, 1'b0);
    run("sub",  6'h00, 6'h22, 32'd3, 32'd5, 16'd0, 4'b0110, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run("slti", 6'h0A, 6'h00, 32'hFFFFFFFD, 32'd0, 16'hFFFF, 4'b0111, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0);
    run("nor",  6'h00, 6'h27, 32'hF0F0F0F0, 32'h0F0F0000, 16'd0, 4'b1100, 32'h0F0F0000, 32'h0000_0F0F, 1'b0, 1'b0, 1'b0);
    run("andi", 6'h0C, 6'h00, 32'hFFFFFFFF, 32'd0, 16'h8001, 4'b0000, 32'h00008001, 32'h00008001, 1'b0, 1'b0, 1'b0);
    run("lw",   6'h23, 6'h00, 32'h100, 32'd0, 16'hFFF0, 4'b0010, 32'hFFFFFFF0, 32'h000000F0, 1'b0, 1'b0, 1'b0);
    run("ori",  6'h0D, 6'h00, 32'd0, 32'd0, 16'h8000, 4'b0001, 32'h00008000, 32'h00008000, 1'b0, 1'b0, 1'b0);
    run("ill_fn", 6'h00, 6'h18, 32'd1, 32'd2, 16'd0, 4'b0001, 32'h00008000, 32'd0, 1'b0, 1'b0, 1'b1);
    run("ill_op", 6'h3F, 6'h00, 32'd1, 32'd2, 16'd0, 4'b0001, 32'h00008000, 32'd0, 1'b0, 1'b0, 1'b1);

    // Backpressure: a second slot waits on in_valid while the first result is held.
    out_ready = 1'b0;
    sb.push_back('{res: 32'd3, z: 1'b0, bt: 1'b0, ill: 1'b0});
    drive(6'h00, 6'h20, 32'd1, 32'd2, 16'd0);
    in_valid = 1'b1;
    step();
    drive(6'h0D, 6'h00, 32'h10, 32'd0, 16'h000F);
    step();
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_result_hold", result, 32'd3);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sel_hold", {28'd0, alu_sel}, 32'b0010);
    end
    pop_check("bp_first");
    out_ready = 1'b1;
    step();
    chk("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_in_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back('{res: 32'h1F, z: 1'b0, bt: 1'b0, ill: 1'b0});
    step();
    in_valid = 1'b0;
    chk("bp_next_sel", {28'd0, alu_sel}, 32'b0001);
    step();
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    pop_check("bp_second");
    step();

    // Reset while holding a result in DONE.
    out_ready = 1'b0;
    drive(6'h00, 6'h20, 32'd40, 32'd2, 16'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rd_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rd_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rd_result", result, 32'd0);
    chk("rd_sel", {28'd0, alu_sel}, 32'd0);
    chk("rd_op1", alu_op1, 32'd0);

    // Reset during EXEC drops the instruction.
    out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("re_no_valid", {31'd0, out_valid}, 32'd0);
    end

    run("post_rst", 6'h00, 6'h2A, 32'd2, 32'd9, 16'd0, 4'b0111, 32'd9, 32'd1, 1'b0, 1'b0, 1'b0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
